fc_in_feeder: RTL

Upstream feeder for the fully-connected layer. It reads packed 64-bit input words from the PCIe-shared block RAM, unpacks them into 16-bit input elements, and streams exactly DIM_INPUT elements per sample to the FC layer with a gap-free valid strobe. It then waits for the layer's result strobe before starting the next sample, repeating for BATCH_NUM samples. It sits between the BRAM controller port and the FC layer `in_dat`/`in_valid` inputs, and is started and monitored by the FC control logic.

---
 rtl/fc_in_feeder_pkg.sv | 24 ++
 rtl/fc_in_feeder_if.sv | 24 ++
 rtl/fc_in_feeder_lane_unpacker.sv | 50 +++++
 rtl/fc_in_feeder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fc_in_feeder_pkg.sv
// Shared types and derived-constant helpers for the FC-layer input feeder.
// Lanes are unpacked from the BRAM word LSB-first: lane 0 is the lowest INPUT_W bits.
package fc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_STREAM,
        ST_WAIT_OUT,
        ST_DONE
    } state_t;

    localparam bit LANE0_IS_LSB = 1'b1;

    function automatic int calc_lanes(input int bram_dat_w, input int input_w);
        return bram_dat_w / input_w;
    endfunction

    function automatic int calc_wps(input int dim_input, input int lanes);
        return dim_input / lanes;
    endfunction

endpackage

// File: rtl/fc_in_feeder_if.sv
// BRAM read port and FC-layer element stream seen by the feeder.
// The master side is the feeder; the slave side is the BRAM plus the FC layer.
interface fc_in_feeder_if #(
    parameter int INPUT_W     = 16,
    parameter int BRAM_DAT_W  = 64,
    parameter int BRAM_ADDR_W = 14
);
    logic                   bram_en;
    logic [BRAM_ADDR_W-1:0] bram_addr;
    logic [BRAM_DAT_W-1:0]  bram_dout;
    logic [INPUT_W-1:0]     fc_in_dat;
    logic                   fc_in_vld;
    logic                   fc_out_vld;

    modport master (
        output bram_en, bram_addr, fc_in_dat, fc_in_vld,
        input  bram_dout, fc_out_vld
    );

    modport slave (
        input  bram_en, bram_addr, fc_in_dat, fc_in_vld,
        output bram_dout, fc_out_vld
    );
endinterface

// File: rtl/fc_in_feeder_lane_unpacker.sv
// Holds one BRAM word and presents it one INPUT_W lane per shift.
// The top decides when to shift and when to reload; this block only tracks the lane position.
module lane_unpacker
    import fc_pkg::*;
#(
    parameter int INPUT_W    = 16,
    parameter int BRAM_DAT_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic [BRAM_DAT_W-1:0] din,
    output logic [INPUT_W-1:0]    lane_dat,
    output logic                  last_lane,
    output logic                  prefetch_lane
);
    localparam int LANES  = calc_lanes(BRAM_DAT_W, INPUT_W);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [BRAM_DAT_W-1:0] sreg;
    logic [LANE_W-1:0]     lane;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
            lane <= '0;
        end else if (load) begin
            sreg <= din;
            lane <= '0;
        end else if (shift) begin
            if (LANE0_IS_LSB)
                sreg <= sreg >> INPUT_W;
            else
                sreg <= sreg << INPUT_W;
            lane <= lane + 1'b1;
        end
    end

    if (LANE0_IS_LSB) begin : g_lsb_first
        assign lane_dat = sreg[INPUT_W-1:0];
    end else begin : g_msb_first
        assign lane_dat = sreg[BRAM_DAT_W-1 -: INPUT_W];
    end

    // The read for the next word goes out two lanes before the end so its data lands on the last lane.
    assign last_lane     = (lane == LANE_W'(LANES - 1));
    assign prefetch_lane = (lane == LANE_W'(LANES - 2));

endmodule

// File: rtl/fc_in_feeder.sv
// Reads packed input words from BRAM and streams DIM_INPUT elements per sample to the FC layer,
// waiting for the layer's result strobe between samples, for BATCH_NUM samples per run.
module fc_in_feeder
    import fc_pkg::*;
#(
    parameter int DIM_INPUT   = 96,
    parameter int INPUT_W     = 16,
    parameter int BRAM_DAT_W  = 64,
    parameter int BRAM_ADDR_W = 14,
    parameter int BATCH_NUM   = 10,
    parameter int BASE_ADDR   = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(BATCH_NUM+1)-1:0]     sample_idx,
    output logic                               err_early,
    fc_in_feeder_if.master                     bus
);
    localparam int LANES  = calc_lanes(BRAM_DAT_W, INPUT_W);
    localparam int WPS    = calc_wps(DIM_INPUT, LANES);
    localparam int ELEM_W = $clog2(DIM_INPUT + 1);
    localparam int WORD_W = $clog2(WPS + 1);
    localparam int SIDX_W = $clog2(BATCH_NUM + 1);
    localparam logic [BRAM_ADDR_W-1:0] BASE = BRAM_ADDR_W'(BASE_ADDR);

    if (BRAM_DAT_W % INPUT_W != 0) begin : g_bad_width
        $error("BRAM_DAT_W must be a multiple of INPUT_W");
    end
    if (LANES < 2 || DIM_INPUT % LANES != 0) begin : g_bad_dim
        $error("DIM_INPUT must be a multiple of LANES and LANES must be at least 2");
    end

    state_t                 state, state_next;
    logic [BRAM_ADDR_W-1:0] addr;
    logic [ELEM_W-1:0]      elem_cnt;
    logic [WORD_W-1:0]      word_cnt;
    logic                   unpack_load, unpack_shift;
    logic                   last_lane, prefetch_lane;
    logic [INPUT_W-1:0]     lane_dat;
    logic                   rd_en, stream_vld;
    logic                   last_elem, last_word, start_ok;

    assign last_elem = (elem_cnt == ELEM_W'(DIM_INPUT - 1));
    assign last_word = (word_cnt == WORD_W'(WPS - 1));
    assign start_ok  = (state == ST_IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next   = state;
        rd_en        = 1'b0;
        stream_vld   = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        unpack_load  = 1'b0;
        unpack_shift = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start)
                    state_next = ST_FETCH;
            end
            ST_FETCH: begin
                busy       = 1'b1;
                rd_en      = 1'b1;
                state_next = ST_LOAD;
            end
            ST_LOAD: begin
                busy        = 1'b1;
                unpack_load = 1'b1;
                state_next  = ST_STREAM;
            end
            ST_STREAM: begin
                busy       = 1'b1;
                stream_vld = 1'b1;
                rd_en      = prefetch_lane && !last_word;
                // The prefetched word is captured while its predecessor's last lane is on the bus.
                if (last_lane)
                    unpack_load = !last_word;
                else
                    unpack_shift = 1'b1;
                if (last_elem)
                    state_next = ST_WAIT_OUT;
            end
            ST_WAIT_OUT: begin
                busy = 1'b1;
                if (bus.fc_out_vld)
                    state_next = (sample_idx < SIDX_W'(BATCH_NUM - 1)) ? ST_FETCH : ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr       <= BASE;
            elem_cnt   <= '0;
            word_cnt   <= '0;
            sample_idx <= '0;
            err_early  <= 1'b0;
        end else begin
            if (start_ok)
                addr <= BASE;
            else if (rd_en)
                addr <= addr + 1'b1;

            if (state == ST_LOAD) begin
                elem_cnt <= '0;
                word_cnt <= '0;
            end else if (state == ST_STREAM) begin
                elem_cnt <= elem_cnt + 1'b1;
                if (last_lane && !last_word)
                    word_cnt <= word_cnt + 1'b1;
            end

            if (start_ok)
                sample_idx <= '0;
            else if (state == ST_WAIT_OUT && bus.fc_out_vld)
                sample_idx <= sample_idx + 1'b1;

            if (start_ok)
                err_early <= 1'b0;
            else if (state == ST_STREAM && bus.fc_out_vld)
                err_early <= 1'b1;
        end
    end

    lane_unpacker #(
        .INPUT_W    (INPUT_W),
        .BRAM_DAT_W (BRAM_DAT_W)
    ) u_unpacker (
        .clk           (clk),
        .rst           (rst),
        .load          (unpack_load),
        .shift         (unpack_shift),
        .din           (bus.bram_dout),
        .lane_dat      (lane_dat),
        .last_lane     (last_lane),
        .prefetch_lane (prefetch_lane)
    );

    assign bus.bram_en   = rd_en;
    assign bus.bram_addr = addr;
    assign bus.fc_in_vld = stream_vld;
    assign bus.fc_in_dat = lane_dat;

endmodule
